// File: rtl/branch_resolve_unit.sv
// Single-entry branch resolution stage: evaluates the condition, computes the target, checks the
// fetch prediction and holds the result behind a valid/ready output with retire statistics.
package branch_resolve_pkg;
    typedef enum logic [2:0] {
        BEQ   = 3'd0,
        BNE   = 3'd1,
        BLT   = 3'd2,
        BGE   = 3'd3,
        BLTU  = 3'd4,
        BGEU  = 3'd5,
        JUMP  = 3'd6,
        NO_BR = 3'd7
    } type_branch_cond_e;
endpackage

module branch_resolve_unit
    import branch_resolve_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   data_rs1,
    input  logic [XLEN-1:0]   data_rs2,
    input  type_branch_cond_e br_type,
    input  logic              is_jalr,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic              pred_taken,
    input  logic [XLEN-1:0]   pred_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              br_taken,
    output logic [XLEN-1:0]   br_target,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  cnt_resolved,
    output logic [CNT_W-1:0]  cnt_mispred
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    logic signed [XLEN-1:0] rs1_s, rs2_s;
    logic                   taken_p0;
    logic                   mispred_p0;
    logic [XLEN-1:0]        target_p0;
    logic [XLEN-1:0]        redirect_p0;

    logic                   vld_p1;
    logic                   taken_p1;
    logic                   mispred_p1;
    logic                   is_br_p1;
    logic [XLEN-1:0]        target_p1;
    logic [XLEN-1:0]        redirect_p1;
    logic [CNT_W-1:0]       cnt_res_q;
    logic [CNT_W-1:0]       cnt_mis_q;

    logic accept;
    logic retire;

    assign rs1_s = data_rs1;
    assign rs2_s = data_rs2;

    // Stage p0: combinational resolution of the incoming op
    always_comb begin
        taken_p0 = 1'b0;
        case (br_type)
            BEQ:     taken_p0 = (data_rs1 == data_rs2);
            BNE:     taken_p0 = (data_rs1 != data_rs2);
            BLT:     taken_p0 = (rs1_s < rs2_s);
            BGE:     taken_p0 = (rs1_s >= rs2_s);
            BLTU:    taken_p0 = (data_rs1 < data_rs2);
            BGEU:    taken_p0 = (data_rs1 >= data_rs2);
            JUMP:    taken_p0 = 1'b1;
            default: taken_p0 = 1'b0;
        endcase
    end

    assign target_p0   = (is_jalr && br_type == JUMP)
                       ? ((data_rs1 + imm) & {{(XLEN-1){1'b1}}, 1'b0})
                       : (pc + imm);
    assign redirect_p0 = taken_p0 ? target_p0 : (pc + XLEN'(4));
    // Target is only compared when both sides agree the branch is taken
    assign mispred_p0  = (taken_p0 != pred_taken)
                       || (taken_p0 && pred_taken && (pred_target != target_p0));

    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign retire   = vld_p1 && out_ready && !flush;

    // Stage p1: output holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            taken_p1    <= 1'b0;
            mispred_p1  <= 1'b0;
            is_br_p1    <= 1'b0;
            target_p1   <= '0;
            redirect_p1 <= '0;
        end else if (flush) begin
            vld_p1      <= 1'b0;
        end else if (accept) begin
            vld_p1      <= 1'b1;
            taken_p1    <= taken_p0;
            mispred_p1  <= mispred_p0;
            is_br_p1    <= (br_type != NO_BR);
            target_p1   <= target_p0;
            redirect_p1 <= redirect_p0;
        end else if (retire) begin
            vld_p1      <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            cnt_res_q <= '0;
            cnt_mis_q <= '0;
        end else if (retire) begin
            if (is_br_p1)   cnt_res_q <= sat_inc(cnt_res_q);
            if (mispred_p1) cnt_mis_q <= sat_inc(cnt_mis_q);
        end
    end

    assign out_valid    = vld_p1;
    assign br_taken     = taken_p1;
    assign br_target    = target_p1;
    assign mispredict   = mispred_p1;
    assign redirect_pc  = redirect_p1;
    assign cnt_resolved = cnt_res_q;
    assign cnt_mispred  = cnt_mis_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a wide-counter instance for function checks and a
// 2-bit-counter instance sharing the same stimulus for saturation checks.
module tb_branch_resolve_unit;
    import branch_resolve_pkg::*;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic        mis;
        logic [31:0] redir;
    } exp_t;

    logic clk = 1'b0;
    logic rst, flush, in_valid, is_jalr, pred_taken, out_ready, cnt_clear;
    logic [31:0] data_rs1, data_rs2, pc, imm, pred_target;
    type_branch_cond_e br_type;

    logic        in_ready, out_valid, br_taken, mispredict;
    logic [31:0] br_target, redirect_pc;
    logic [15:0] cnt_resolved, cnt_mispred;

    logic        in_ready_s, out_valid_s, br_taken_s, mispredict_s;
    logic [31:0] br_target_s, redirect_pc_s;
    logic [1:0]  cnt_res_s, cnt_mis_s;

    int n_checks = 0, n_fail = 0, mon_checks = 0, mon_fail = 0, n_retired = 0;
    exp_t sb[$];
    exp_t e_mon;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .data_rs1(data_rs1), .data_rs2(data_rs2), .br_type(br_type), .is_jalr(is_jalr),
        .pc(pc), .imm(imm), .pred_taken(pred_taken), .pred_target(pred_target),
        .out_valid(out_valid), .out_ready(out_ready), .br_taken(br_taken), .br_target(br_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .cnt_clear(cnt_clear),
        .cnt_resolved(cnt_resolved), .cnt_mispred(cnt_mispred)
    );

    branch_resolve_unit #(.XLEN(32), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
        .data_rs1(data_rs1), .data_rs2(data_rs2), .br_type(br_type), .is_jalr(is_jalr),
        .pc(pc), .imm(imm), .pred_taken(pred_taken), .pred_target(pred_target),
        .out_valid(out_valid_s), .out_ready(out_ready), .br_taken(br_taken_s),
        .br_target(br_target_s), .mispredict(mispredict_s), .redirect_pc(redirect_pc_s),
        .cnt_clear(cnt_clear), .cnt_resolved(cnt_res_s), .cnt_mispred(cnt_mis_s)
    );

    function automatic exp_t model(input type_branch_cond_e t, input logic jalr,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [31:0] p, input logic [31:0] im,
                                   input logic pt, input logic [31:0] ptgt);
        exp_t e;
        case (t)
            BEQ:     e.taken = (r1 == r2);
            BNE:     e.taken = (r1 != r2);
            BLT:     e.taken = ($signed(r1) < $signed(r2));
            BGE:     e.taken = !($signed(r1) < $signed(r2));
            BLTU:    e.taken = (r1 < r2);
            BGEU:    e.taken = !(r1 < r2);
            JUMP:    e.taken = 1'b1;
            default: e.taken = 1'b0;
        endcase
        e.target = (t == JUMP && jalr) ? ((r1 + im) & 32'hFFFF_FFFE) : (p + im);
        e.redir  = e.taken ? e.target : (p + 32'd4);
        e.mis    = (e.taken != pt) || (e.taken && pt && (ptgt != e.target));
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on retire, drop everything on flush/reset
    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                mon_checks++;
                if (sb.size() == 0) begin
                    mon_fail++;
                    $display("FAIL sb_underflow: retire with no expected op (taken=%0b target=%h)",
                             br_taken, br_target);
                end else begin
                    e_mon = sb.pop_front();
                    n_retired++;
                    if ({br_taken, br_target, mispredict, redirect_pc} !== e_mon) begin
                        mon_fail++;
                        $display("FAIL sb_result: got taken=%0b tgt=%h mis=%0b redir=%h, want taken=%0b tgt=%h mis=%0b redir=%h",
                                 br_taken, br_target, mispredict, redirect_pc,
                                 e_mon.taken, e_mon.target, e_mon.mis, e_mon.redir);
                    end
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model(br_type, is_jalr, data_rs1, data_rs2, pc, imm,
                                   pred_taken, pred_target));
        end
    end

    task automatic set_op(input type_branch_cond_e t, input logic jalr, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] p, input logic [31:0] im,
                          input logic pt, input logic [31:0] ptgt);
        br_type = t; is_jalr = jalr; data_rs1 = r1; data_rs2 = r2;
        pc = p; imm = im; pred_taken = pt; pred_target = ptgt;
    endtask

    // Presents one op and returns at posedge+1 after the edge that accepted it
    task automatic issue(input type_branch_cond_e t, input logic jalr, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] p, input logic [31:0] im,
                         input logic pt, input logic [31:0] ptgt);
        logic acc;
        acc = 1'b0;
        set_op(t, jalr, r1, r2, p, im, pt, ptgt);
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL issue_timeout: in_ready=%0b, required 1 within 50 cycles", in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0;
        set_op(NO_BR, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if ({out_valid, br_taken, mispredict, br_target, redirect_pc} !== 67'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: vld=%0b tk=%0b mis=%0b tgt=%h redir=%h, required all 0",
                     out_valid, br_taken, mispredict, br_target, redirect_pc);
        end
        n_checks++;
        if (cnt_resolved !== 16'd0 || cnt_mispred !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: res=%0d mis=%0d, required 0 0", cnt_resolved, cnt_mispred);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
        end
    endtask

    task automatic test_signed_unsigned();
        issue(BLT, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0);
        n_checks++;
        if ({br_taken, br_target, mispredict, redirect_pc} !== {1'b1, 32'h120, 1'b1, 32'h120}) begin
            n_fail++;
            $display("FAIL blt_signed: tk=%0b tgt=%h mis=%0b redir=%h, required 1 120 1 120",
                     br_taken, br_target, mispredict, redirect_pc);
        end
        issue(BLTU, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0);
        n_checks++;
        if ({br_taken, mispredict, redirect_pc} !== {1'b0, 1'b0, 32'h104}) begin
            n_fail++;
            $display("FAIL bltu_unsigned: tk=%0b mis=%0b redir=%h, required 0 0 104",
                     br_taken, mispredict, redirect_pc);
        end
    endtask

    task automatic test_jalr();
        issue(JUMP, 1'b1, 32'h1003, 32'h0, 32'h500, 32'h4, 1'b1, 32'h1006);
        n_checks++;
        if ({br_taken, br_target, mispredict} !== {1'b1, 32'h1006, 1'b0}) begin
            n_fail++;
            $display("FAIL jalr_hit: tk=%0b tgt=%h mis=%0b, required 1 1006 0",
                     br_taken, br_target, mispredict);
        end
        issue(JUMP, 1'b1, 32'h1003, 32'h0, 32'h500, 32'h4, 1'b1, 32'h1008);
        n_checks++;
        if ({br_target, mispredict} !== {32'h1006, 1'b1}) begin
            n_fail++;
            $display("FAIL jalr_wrong_target: tgt=%h mis=%0b, required 1006 1", br_target, mispredict);
        end
        issue(NO_BR, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h40, 1'b1, 32'h0);
        n_checks++;
        if ({br_taken, mispredict, redirect_pc} !== {1'b0, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL nobr_pred_taken_wrap: tk=%0b mis=%0b redir=%h, required 0 1 0",
                     br_taken, mispredict, redirect_pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [5];
        logic [31:0] r1, r2, p, im;
        pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF;
        pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF;
        for (int i = 0; i < 24; i++) begin
            r1 = pool[$urandom_range(0, 4)];
            r2 = pool[$urandom_range(0, 4)];
            p  = $urandom & 32'hFFFF_FFFC;
            im = $urandom_range(0, 1) ? 32'h10 : 32'hFFFF_FFF0;
            issue(type_branch_cond_e'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), r1, r2, p, im,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 1) ? (p + im) : (r1 + im) & 32'hFFFF_FFFE);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int ret0;
        exp_t snap;
        cnt_clear = 1'b1; @(posedge clk); #1; cnt_clear = 1'b0;
        ret0 = n_retired;
        out_ready = 1'b0;
        set_op(BEQ, 1'b0, 32'h5, 32'h5, 32'h1000, 32'h8, 1'b1, 32'h1008);
        in_valid = 1'b1;
        @(posedge clk); #1;
        snap = {br_taken, br_target, mispredict, redirect_pc};
        set_op(BNE, 1'b0, 32'h5, 32'h5, 32'h2000, 32'h8, 1'b1, 32'h2008);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_in_ready: cycle %0d got %0b, required 0", i, in_ready);
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || {br_taken, br_target, mispredict, redirect_pc} !== snap) begin
                n_fail++;
                $display("FAIL stall_stable: cycle %0d vld=%0b tgt=%h redir=%h, required 1 %h %h",
                         i, out_valid, br_target, redirect_pc, snap.target, snap.redir);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        set_op(BGE, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h3000, 32'h8, 1'b0, 32'h0);
        @(posedge clk); #1;
        set_op(JUMP, 1'b0, 32'h0, 32'h0, 32'h4000, 32'h100, 1'b1, 32'h4100);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (n_retired - ret0 !== 4 || sb.size() !== 0) begin
            n_fail++;
            $display("FAIL stream_count: retired=%0d pending=%0d, required 4 0", n_retired - ret0, sb.size());
        end
        n_checks++;
        if (cnt_resolved !== 16'd4) begin
            n_fail++;
            $display("FAIL stream_cnt_resolved: got %0d, required 4", cnt_resolved);
        end
    endtask

    task automatic test_flush();
        logic [15:0] c_r, c_m;
        out_ready = 1'b1;
        c_r = cnt_resolved; c_m = cnt_mispred;
        issue(BEQ, 1'b0, 32'h7, 32'h7, 32'h600, 32'h40, 1'b0, 32'h0);
        set_op(BNE, 1'b0, 32'h1, 32'h2, 32'h700, 32'h40, 1'b0, 32'h0);
        in_valid = 1'b1; flush = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_setup: in_ready=%0b out_valid=%0b, required 1 1", in_ready, out_valid);
        end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_out_valid: got %0b, required 0", out_valid);
        end
        n_checks++;
        if (cnt_resolved !== c_r || cnt_mispred !== c_m) begin
            n_fail++;
            $display("FAIL flush_counters: res=%0d mis=%0d, required %0d %0d",
                     cnt_resolved, cnt_mispred, c_r, c_m);
        end
        issue(BNE, 1'b0, 32'h1, 32'h2, 32'h800, 32'h40, 1'b1, 32'h840);
        n_checks++;
        if ({out_valid, br_taken, mispredict, br_target} !== {1'b1, 1'b1, 1'b0, 32'h840}) begin
            n_fail++;
            $display("FAIL flush_next_op: vld=%0b tk=%0b mis=%0b tgt=%h, required 1 1 0 840",
                     out_valid, br_taken, mispredict, br_target);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturate_clear_reset();
        cnt_clear = 1'b1; @(posedge clk); #1; cnt_clear = 1'b0;
        for (int i = 0; i < 5; i++)
            issue(BEQ, 1'b0, 32'h9, 32'h9, 32'h900 + 32'(i * 4), 32'h20, 1'b0, 32'h0);
        @(posedge clk); #1;
        n_checks++;
        if (cnt_mis_s !== 2'd3 || cnt_res_s !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_cnt_w2: mis=%0d res=%0d, required 3 3", cnt_mis_s, cnt_res_s);
        end
        n_checks++;
        if (cnt_mispred !== 16'd5) begin
            n_fail++;
            $display("FAIL sat_cnt_w16: mis=%0d, required 5", cnt_mispred);
        end
        issue(BEQ, 1'b0, 32'h9, 32'h9, 32'hA00, 32'h20, 1'b0, 32'h0);
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        n_checks++;
        if (cnt_mis_s !== 2'd0 || cnt_mispred !== 16'd0 || cnt_resolved !== 16'd0) begin
            n_fail++;
            $display("FAIL clear_vs_retire: mis_s=%0d mis=%0d res=%0d, required 0 0 0",
                     cnt_mis_s, cnt_mispred, cnt_resolved);
        end
        out_ready = 1'b0;
        issue(JUMP, 1'b0, 32'h0, 32'h0, 32'h200, 32'h8, 1'b0, 32'h0);
        n_checks++;
        if (out_valid !== 1'b1 || br_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_setup: vld=%0b tk=%0b, required 1 1", out_valid, br_taken);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({out_valid, br_taken, mispredict, br_target, redirect_pc, cnt_resolved, cnt_mispred} !== 99'h0
            || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_op: vld=%0b tk=%0b mis=%0b tgt=%h redir=%h rdy=%0b, required 0 0 0 0 0 1",
                     out_valid, br_taken, mispredict, br_target, redirect_pc, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_signed_unsigned();
        test_jalr();
        test_random();
        test_back_to_back();
        test_flush();
        test_saturate_clear_reset();
        repeat (2) @(posedge clk);
        n_checks += mon_checks;
        n_fail   += mon_fail;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
